seg_display_ctrl: RTL and testbench
===================================

# seg_display_ctrl

Display controller for the seven-segment output path. It synchronises and debounces the board's ALU/PC view switch, and captures the selected 32-bit source into a stable snapshot on instruction commit. It then time-multiplexes the eight hex digits onto a shared, active-low segment bus. It sits between the core's ALU_Output/PC_out nets and the board display pins.

## Interface
- REFRESH_DIV, 50000: clocks per digit slot; minimum 2.
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronised cycles required to accept a switch change; minimum 1.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- switch  in  1  raw view switch, asynchronous: 1 = ALU view, 0 = PC view.
- ALU_Output  in  32  ALU result.
- PC_out  in  32  current program counter.
- commit  in  1  one-cycle strobe when an instruction retires.
- freeze  in  1  level; 1 holds the snapshot against commit updates.
- sel_alu  out  1  debounced view select.
- seg_n  out  7  segments, active-low; bit0 = a … bit6 = g.
- dp_n  out  1  decimal point, active-low.
- an_n  out  8  digit enables, active-low, one-hot-low; bit i = digit i (nibble i).

## Operation
- **Synchroniser:** switch passes through 2 flip-flops to give sync_q.
- **Debouncer:**
  - Counter cnt runs over 0..DEBOUNCE_CYCLES-1.
  - If sync_q == sel_alu: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: sel_alu <= sync_q, cnt <= 0, and sel_chg pulses for 1 cycle.
  - Else: cnt++.
  - Any bounce back to sel_alu before terminal count clears cnt.
- **Snapshot register snap[31:0]:** priority is reset > sel_chg > commit.
  - On sel_chg: load the source for the new sel_alu value. This ignores freeze.
  - Else on commit & !freeze: load (sel_alu ? ALU_Output : PC_out).
  - commit with freeze=1 is dropped; it is not queued.
- **Scanner:**
  - Prescaler p runs over 0..REFRESH_DIV-1; digit index d runs over 0..7.
  - When p == REFRESH_DIV-1: p <= 0 and d <= d+1 mod 8 (7 wraps to 0). Otherwise p++.
- **Output registers:** updated every cycle from the current p, d and snap.
  - If p == 0 (blank slot): an_n <= 8'hFF, seg_n <= 7'h7F, dp_n <= 1.
  - Else: an_n <= ~(1<<d), seg_n <= hex(snap[4d+3:4d]), and dp_n <= ~(sel_alu & d==0). The DP on digit 0 marks ALU view.
- **hex() map (seg_n, g..a):**
  - 0:40, 1:79, 2:24, 3:30
  - 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03
  - C:46, d:21, E:06, F:0E

## Timing
- **Reset values:** sel_alu=0, snap=0, cnt=0, p=0, d=0, both sync flops=0, sel_chg=0, an_n=FF, seg_n=7F, dp_n=1.
- **Assertion mid-scan:** reset asserted mid-scan returns all state to the reset values on the next edge.
- **Switch latency:**
  - A raw change held stable appears on sel_alu exactly DEBOUNCE_CYCLES+2 clocks after the first edge that samples it.
  - snap reflects the new source 1 clock after sel_alu changes.
- **Commit latency:** snap updates on the edge that samples commit=1. Display outputs reflect the new snap 1 clock later.
- **Output latency:** outputs are registered, 1 clock behind p/d/snap.
  - Each digit is lit for REFRESH_DIV-1 clocks, preceded by 1 blank clock (anti-ghosting).
  - Full frame is 8·REFRESH_DIV clocks.
- **After reset release:**
  - First edge: outputs stay blank (p=0).
  - Second edge: an_n = FE.
- **Simultaneous events:**
  - sel_chg and commit in the same cycle: a single load of the new-view source.
  - Source inputs changing without commit or sel_chg do not affect the display.

## Test plan
Use REFRESH_DIV=4 and DEBOUNCE_CYCLES=3.
- **Reset/scan:** deassert reset with snap=0.
  - an_n sequence from the first post-reset edge: FF, FE, FE, FE, FF, FD, …, 7F, then wraps to FE.
  - seg_n is 40 while lit and 7F while blank; dp_n stays 1.
- **Commit capture:** PC_out=0x89ABCDEF, commit pulse.
  - Digit 0 shows 0E (F), digit 1 shows 06 (E), digit 7 shows 00 (8).
  - Changing PC_out afterwards without commit leaves the display unchanged.
- **Freeze:** freeze=1, PC_out=0x12345678, commit. snap is unchanged. Release freeze and commit again: snap=0x12345678, digit 0 shows 00.
- **Debounce:**
  - switch 0→1 for 2 cycles then back to 0: sel_alu stays 0.
  - switch held at 1: sel_alu=1 exactly 5 clocks after the first sampling edge.
  - Next clock: snap=ALU_Output (e.g. 0x0000000A), even with freeze=1. Digit 0 shows seg_n 08 with dp_n 0.
- **Simultaneous:** sel_chg coinciding with commit while ALU_Output=0xFFFFFFFF. snap=FFFFFFFF and all digits show 0E.
- **Mid-operation reset:** assert reset during digit 5.
  - Next edge: an_n=FF, snap=0, sel_alu=0.
  - Scan restarts at digit 0.

Source files
------------

// File: rtl/seg_display_ctrl.sv
// ============================================================================
//  Module   : seg_display_ctrl
//  Function : switch debounce, commit-driven snapshot and 8-digit hex scanner
//  Revision : 1.0
// ============================================================================
`default_nettype none

module seg_display_ctrl #(
   parameter int REFRESH_DIV     = 50000,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        switch,
   input  logic [31:0] ALU_Output,
   input  logic [31:0] PC_out,
   input  logic        commit,
   input  logic        freeze,
   output logic        sel_alu,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic [7:0]  an_n
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int P_W   = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [P_W-1:0]   C_P_LAST   = P_W'(REFRESH_DIV - 1);

   logic             sync1_q, sync_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sel_q, sel_d;
   logic             chg_q, chg_d;
   logic [31:0]      snap_q, snap_d;
   logic [P_W-1:0]   p_q, p_d;
   logic [2:0]       dig_q, dig_d;
   logic [7:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic [3:0]       w_nib;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
      endcase
   endfunction

   // Debouncer: any return to the accepted level restarts the stability count
   always_comb begin
      cnt_d = cnt_q;
      sel_d = sel_q;
      chg_d = 1'b0;
      if (sync_q == sel_q) begin
         cnt_d = '0;
      end else if (cnt_q == C_CNT_LAST) begin
         sel_d = sync_q;
         cnt_d = '0;
         chg_d = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // A view change reloads regardless of freeze; it also absorbs a same-cycle commit
   always_comb begin
      snap_d = snap_q;
      if (chg_q || (commit && !freeze)) begin
         snap_d = sel_q ? ALU_Output : PC_out;
      end
   end

   always_comb begin
      p_d   = p_q + 1'b1;
      dig_d = dig_q;
      if (p_q == C_P_LAST) begin
         p_d   = '0;
         dig_d = dig_q + 1'b1;
      end
   end

   assign w_nib = snap_q[{dig_q, 2'b00} +: 4];

   // Slot position 0 is left dark so the previous digit never ghosts onto the next
   always_comb begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (p_q != '0) begin
         an_d  = ~(8'b1 << dig_q);
         seg_d = hex7(w_nib);
         dp_d  = ~(sel_q && (dig_q == 3'd0));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync_q  <= 1'b0;
         cnt_q   <= '0;
         sel_q   <= 1'b0;
         chg_q   <= 1'b0;
         snap_q  <= '0;
         p_q     <= '0;
         dig_q   <= '0;
         an_q    <= 8'hFF;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
      end else begin
         sync1_q <= switch;
         sync_q  <= sync1_q;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         chg_q   <= chg_d;
         snap_q  <= snap_d;
         p_q     <= p_d;
         dig_q   <= dig_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign sel_alu = sel_q;
   assign seg_n   = seg_q;
   assign dp_n    = dp_q;
   assign an_n    = an_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_ctrl.sv
// ============================================================================
//  Module   : tb_seg_display_ctrl
//  Function : randomized self-checking bench against a slot-arithmetic model
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg_display_ctrl;

   localparam int R = 4;
   localparam int D = 3;
   localparam int FRAME = 8 * R;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        switch = 1'b0;
   logic [31:0] ALU_Output = '0;
   logic [31:0] PC_out = '0;
   logic        commit = 1'b0;
   logic        freeze = 1'b0;
   logic        sel_alu;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [7:0]  an_n;

   int total = 0;
   int bad = 0;

   // Model state: pend_* is what the design should hold after the next edge
   int          n_since = 0;
   logic [31:0] pend_snap = '0, cur_snap = '0, disp_snap = '0;
   logic        pend_sel = 1'b0, cur_sel = 1'b0, disp_sel = 1'b0;

   logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg_display_ctrl #(.REFRESH_DIV(R), .DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .reset(reset), .switch(switch), .ALU_Output(ALU_Output),
      .PC_out(PC_out), .commit(commit), .freeze(freeze), .sel_alu(sel_alu),
      .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      disp_snap <= cur_snap;
      disp_sel  <= cur_sel;
      if (reset) begin
         n_since  <= 0;
         cur_snap <= '0;
         cur_sel  <= 1'b0;
      end else begin
         n_since  <= n_since + 1;
         cur_snap <= pend_snap;
         cur_sel  <= pend_sel;
      end
   end

   // Expected {an_n, seg_n, dp_n} after the n-th edge since reset release
   function automatic logic [15:0] exp_out(int n, logic [31:0] s, logic sl);
      int slot, d;
      if (n == 0 || ((n - 1) % R) == 0) return {8'hFF, 7'h7F, 1'b1};
      slot = n - 1;
      d = (slot / R) % 8;
      return {~(8'd1 << d), HEX[(s >> (4 * d)) & 32'hF], ~(sl && d == 0)};
   endfunction

   task automatic commit_pulse(input logic [31:0] v);
      @(negedge clk);
      PC_out = v;
      ALU_Output = $urandom;
      commit = 1'b1;
      if (!freeze) pend_snap = pend_sel ? ALU_Output : PC_out;
      @(negedge clk);
      commit = 1'b0;
      PC_out = $urandom;
   endtask

   task automatic flip_switch(input logic v, input logic with_commit);
      @(negedge clk);
      switch = v;
      for (int i = 1; i <= D + 2; i++) begin
         if (i == D + 2) pend_sel = v;
         @(negedge clk);
      end
      pend_snap = v ? ALU_Output : PC_out;
      commit = with_commit;
      @(negedge clk);
      commit = 1'b0;
   endtask

   task automatic test_reset;
      logic [7:0] seq [6];
      seq = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD};
      reset = 1'b1;
      pend_snap = '0;
      pend_sel = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({an_n, seg_n, dp_n, sel_alu} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL reset_state: got an=%h seg=%h dp=%b sel=%b want FF 7F 1 0", an_n, seg_n, dp_n, sel_alu);
      end
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++;
         if (an_n !== seq[i]) begin
            bad++;
            $display("FAIL reset_an_seq[%0d]: got %h want %h", i, an_n, seq[i]);
         end
      end
      for (int i = 0; i < FRAME + 4; i++) begin
         logic [15:0] e;
         @(negedge clk);
         e = exp_out(n_since, disp_snap, disp_sel);
         total++;
         if ({an_n, seg_n, dp_n} !== e) begin
            bad++;
            $display("FAIL reset_scan n=%0d: got %h/%h/%b want %h/%h/%b", n_since, an_n, seg_n, dp_n, e[15:8], e[7:1], e[0]);
         end
      end
   endtask

   task automatic test_commit;
      for (int k = 0; k < 3; k++) begin
         commit_pulse(k == 0 ? 32'h89ABCDEF : $urandom);
         for (int i = 0; i < FRAME + 2; i++) begin
            logic [15:0] e;
            @(negedge clk);
            if (i == 3) PC_out = $urandom;
            e = exp_out(n_since, disp_snap, disp_sel);
            total++;
            if ({an_n, seg_n, dp_n} !== e) begin
               bad++;
               $display("FAIL commit_disp k=%0d n=%0d: got %h/%h/%b want %h/%h/%b", k, n_since, an_n, seg_n, dp_n, e[15:8], e[7:1], e[0]);
            end
         end
      end
   endtask

   task automatic test_freeze;
      for (int k = 0; k < 5; k++) begin
         freeze = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : 1'($urandom_range(0, 1));
         commit_pulse(k < 2 ? 32'h12345678 : $urandom);
         freeze = 1'b0;
         for (int i = 0; i < FRAME + 2; i++) begin
            logic [15:0] e;
            @(negedge clk);
            e = exp_out(n_since, disp_snap, disp_sel);
            total++;
            if ({an_n, seg_n, dp_n} !== e) begin
               bad++;
               $display("FAIL freeze_disp k=%0d n=%0d: got %h/%h/%b want %h/%h/%b", k, n_since, an_n, seg_n, dp_n, e[15:8], e[7:1], e[0]);
            end
         end
      end
   endtask

   task automatic test_debounce;
      int k;
      k = $urandom_range(1, D - 1);
      @(negedge clk);
      switch = 1'b1;
      repeat (k) @(negedge clk);
      switch = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if (sel_alu !== 1'b0) begin
            bad++;
            $display("FAIL bounce_ignored k=%0d: got sel=%b want 0", k, sel_alu);
         end
      end
      ALU_Output = 32'h0000000A;
      freeze = 1'b1;
      switch = 1'b1;
      for (int i = 1; i <= D + 2; i++) begin
         if (i == D + 2) pend_sel = 1'b1;
         @(negedge clk);
         total++;
         if (sel_alu !== (i == D + 2)) begin
            bad++;
            $display("FAIL debounce_latency edge=%0d: got sel=%b want %b", i, sel_alu, i == D + 2);
         end
      end
      pend_snap = ALU_Output;
      for (int i = 0; i < FRAME + 2; i++) begin
         logic [15:0] e;
         @(negedge clk);
         if (i == 1) ALU_Output = $urandom;
         e = exp_out(n_since, disp_snap, disp_sel);
         total++;
         if ({an_n, seg_n, dp_n, sel_alu} !== {e, 1'b1}) begin
            bad++;
            $display("FAIL debounce_disp n=%0d: got %h/%h/%b sel=%b want %h/%h/%b sel=1", n_since, an_n, seg_n, dp_n, sel_alu, e[15:8], e[7:1], e[0]);
         end
      end
      freeze = 1'b0;
   endtask

   task automatic test_simultaneous;
      PC_out = $urandom;
      flip_switch(1'b0, 1'b0);
      ALU_Output = 32'hFFFFFFFF;
      flip_switch(1'b1, 1'b1);
      ALU_Output = $urandom;
      for (int i = 0; i < FRAME + 2; i++) begin
         logic [15:0] e;
         @(negedge clk);
         e = exp_out(n_since, 32'hFFFFFFFF, 1'b1);
         total++;
         if ({an_n, seg_n, dp_n, sel_alu} !== {e, 1'b1}) begin
            bad++;
            $display("FAIL simultaneous n=%0d: got %h/%h/%b sel=%b want %h/%h/%b sel=1", n_since, an_n, seg_n, dp_n, sel_alu, e[15:8], e[7:1], e[0]);
         end
      end
   endtask

   task automatic test_mid_reset;
      int guard;
      guard = 0;
      while (!(n_since > 0 && ((n_since - 1) % R) != 0 && (((n_since - 1) / R) % 8) == 5) && guard < 4 * FRAME) begin
         @(negedge clk);
         guard++;
      end
      total++;
      if (an_n !== 8'hDF) begin
         bad++;
         $display("FAIL reach_digit5: got an=%h want DF", an_n);
      end
      reset = 1'b1;
      switch = 1'b0;
      pend_snap = '0;
      pend_sel = 1'b0;
      @(negedge clk);
      total++;
      if ({an_n, seg_n, dp_n, sel_alu} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL mid_reset: got an=%h seg=%h dp=%b sel=%b want FF 7F 1 0", an_n, seg_n, dp_n, sel_alu);
      end
      reset = 1'b0;
      for (int i = 0; i < FRAME + 2; i++) begin
         logic [15:0] e;
         @(negedge clk);
         e = exp_out(n_since, 32'h0, 1'b0);
         total++;
         if ({an_n, seg_n, dp_n} !== e) begin
            bad++;
            $display("FAIL restart_scan n=%0d: got %h/%h/%b want %h/%h/%b", n_since, an_n, seg_n, dp_n, e[15:8], e[7:1], e[0]);
         end
      end
   endtask

   initial begin
      test_reset;
      test_commit;
      test_freeze;
      test_debounce;
      test_simultaneous;
      test_mid_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
